// File: rtl/ras_pkg.sv
// Shared defaults and checkpoint record for the return-address stack.
package ras_pkg;

   localparam int RAS_AW         = 14;
   localparam int RAS_DEPTH_LOG2 = 4;
   localparam int RAS_NCKPT      = 4;

   // Default-width checkpoint record; the stack passes its own sized variant.
   typedef struct packed {
      logic [RAS_DEPTH_LOG2-1:0] sp;
      logic [RAS_DEPTH_LOG2:0]   count;
      logic [RAS_AW-1:0]         top;
      logic                      valid;
   } ras_ckpt_t;

endpackage

// File: rtl/ras_ckpt_file.sv
// Checkpoint slots for stack rollback; only the valid bits are cleared.
module ras_ckpt_file
   import ras_pkg::*;
#(
   parameter int  NCKPT  = RAS_NCKPT,
   parameter type ckpt_t = ras_ckpt_t
) (
   input  logic                     clk,
   input  logic                     clear,
   input  logic                     save,
   input  logic [$clog2(NCKPT)-1:0] id,
   input  ckpt_t                    save_data,
   output ckpt_t                    rd_data
);

   ckpt_t slots [NCKPT];

   always_ff @(posedge clk) begin
      if (clear) begin
         for (int i = 0; i < NCKPT; i++) begin
            slots[i].valid <= 1'b0;
         end
      end else if (save) begin
         slots[id] <= save_data;
      end
   end

   assign rd_data = slots[id];

endmodule

// File: rtl/ret_addr_stack.sv
// Circular return-address stack with checkpoint rollback for the fetch unit.
module ret_addr_stack
   import ras_pkg::*;
#(
   parameter int AW         = RAS_AW,
   parameter int DEPTH_LOG2 = RAS_DEPTH_LOG2,
   parameter int NCKPT      = RAS_NCKPT
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic [AW-1:0]            push_addr,
   input  logic                     pop,
   output logic [AW-1:0]            ra,
   output logic                     ra_valid,
   output logic [DEPTH_LOG2:0]      count,
   output logic                     overflow,
   output logic                     underflow,
   input  logic                     ckpt_save,
   input  logic                     ckpt_restore,
   input  logic [$clog2(NCKPT)-1:0] ckpt_id
);

   localparam int                DEPTH    = 2 ** DEPTH_LOG2;
   localparam logic [DEPTH_LOG2:0] FULL_CNT = (DEPTH_LOG2 + 1)'(DEPTH);

   typedef struct packed {
      logic [DEPTH_LOG2-1:0] sp;
      logic [DEPTH_LOG2:0]   count;
      logic [AW-1:0]         top;
      logic                  valid;
   } ckpt_t;

   logic [AW-1:0]         mem [DEPTH];
   logic [DEPTH_LOG2-1:0] sp;
   logic [DEPTH_LOG2-1:0] sp_inc;
   logic [DEPTH_LOG2-1:0] sp_dec;
   logic                  empty;
   logic                  full;
   logic                  save_en;
   ckpt_t                 save_data;
   ckpt_t                 rd_data;

   assign sp_inc    = sp + 1'b1;
   assign sp_dec    = sp - 1'b1;
   assign empty     = (count == '0);
   assign full      = (count == FULL_CNT);
   assign ra        = empty ? '0 : mem[sp];
   assign ra_valid  = !empty;
   // A restore in the same cycle wins, so the save is dropped.
   assign save_en   = ckpt_save && !ckpt_restore;
   assign save_data = '{sp: sp, count: count, top: mem[sp], valid: 1'b1};

   ras_ckpt_file #(
      .NCKPT  (NCKPT),
      .ckpt_t (ckpt_t)
   ) u_ckpt (
      .clk       (clk),
      .clear     (rst),
      .save      (save_en),
      .id        (ckpt_id),
      .save_data (save_data),
      .rd_data   (rd_data)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         sp        <= '0;
         count     <= '0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         overflow  <= 1'b0;
         underflow <= 1'b0;
         if (ckpt_restore) begin
            if (rd_data.valid) begin
               sp    <= rd_data.sp;
               count <= rd_data.count;
            end else begin
               sp    <= '0;
               count <= '0;
            end
         end else if (push && pop) begin
            if (empty) begin
               count <= {{DEPTH_LOG2{1'b0}}, 1'b1};
            end
         end else if (push) begin
            sp       <= sp_inc;
            overflow <= full;
            if (!full) begin
               count <= count + 1'b1;
            end
         end else if (pop) begin
            if (empty) begin
               underflow <= 1'b1;
            end else begin
               sp    <= sp_dec;
               count <= count - 1'b1;
            end
         end
      end
   end

   // Entry memory is deliberately not reset; count gates what is visible.
   always_ff @(posedge clk) begin
      if (!rst) begin
         if (ckpt_restore) begin
            if (rd_data.valid) begin
               mem[rd_data.sp] <= rd_data.top;
            end
         end else if (push && pop) begin
            mem[sp] <= push_addr;
         end else if (push) begin
            mem[sp_inc] <= push_addr;
         end
      end
   end

endmodule

// File: tb/tb_ret_addr_stack.sv
// Bench for ret_addr_stack: directed vector table, corner sequences, random vs model.
module tb_ret_addr_stack;

   localparam int AW    = 14;
   localparam int DL2   = 2;
   localparam int DEPTH = 4;
   localparam int NCK   = 4;

   logic              clk = 1'b0;
   logic              rst;
   logic              push;
   logic [AW-1:0]     push_addr;
   logic              pop;
   logic [AW-1:0]     ra;
   logic              ra_valid;
   logic [DL2:0]      count;
   logic              overflow;
   logic              underflow;
   logic              ckpt_save;
   logic              ckpt_restore;
   logic [1:0]        ckpt_id;

   int checks = 0;
   int errors = 0;

   ret_addr_stack #(.AW(AW), .DEPTH_LOG2(DL2), .NCKPT(NCK)) dut (
      .clk          (clk),
      .rst          (rst),
      .push         (push),
      .push_addr    (push_addr),
      .pop          (pop),
      .ra           (ra),
      .ra_valid     (ra_valid),
      .count        (count),
      .overflow     (overflow),
      .underflow    (underflow),
      .ckpt_save    (ckpt_save),
      .ckpt_restore (ckpt_restore),
      .ckpt_id      (ckpt_id)
   );

   always #5 clk = ~clk;

   // Reference model: circular array with a top index, as the stack is defined.
   int  m_mem [DEPTH];
   int  m_sp;
   int  m_cnt;
   bit  m_ovf;
   bit  m_unf;
   typedef struct {
      int sp;
      int cnt;
      int top;
      bit valid;
   } mck_t;
   mck_t m_ck [NCK];

   task automatic model_step();
      if (rst) begin
         m_sp = 0; m_cnt = 0; m_ovf = 0; m_unf = 0;
         for (int i = 0; i < NCK; i++) m_ck[i].valid = 0;
         return;
      end
      m_ovf = 0;
      m_unf = 0;
      if (ckpt_restore) begin
         if (m_ck[ckpt_id].valid) begin
            m_sp  = m_ck[ckpt_id].sp;
            m_cnt = m_ck[ckpt_id].cnt;
            m_mem[m_sp] = m_ck[ckpt_id].top;
         end else begin
            m_sp = 0; m_cnt = 0;
         end
      end else begin
         if (ckpt_save) m_ck[ckpt_id] = '{m_sp, m_cnt, m_mem[m_sp], 1'b1};
         if (push && pop) begin
            m_mem[m_sp] = int'(push_addr);
            if (m_cnt == 0) m_cnt = 1;
         end else if (push) begin
            m_sp = (m_sp + 1) % DEPTH;
            m_mem[m_sp] = int'(push_addr);
            if (m_cnt == DEPTH) m_ovf = 1;
            else m_cnt++;
         end else if (pop) begin
            if (m_cnt == 0) m_unf = 1;
            else begin
               m_sp = (m_sp + DEPTH - 1) % DEPTH;
               m_cnt--;
            end
         end
      end
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic chk_outs(input string tag, input logic [AW-1:0] e_ra, input bit e_v,
                           input int e_cnt, input bit e_o, input bit e_u);
      chk({tag, " ra"},        32'(ra),        32'(e_ra));
      chk({tag, " ra_valid"},  32'(ra_valid),  32'(e_v));
      chk({tag, " count"},     32'(count),     32'(e_cnt));
      chk({tag, " overflow"},  32'(overflow),  32'(e_o));
      chk({tag, " underflow"}, 32'(underflow), 32'(e_u));
   endtask

   task automatic chk_model(input string tag);
      chk_outs(tag, (m_cnt != 0) ? AW'(m_mem[m_sp]) : '0, m_cnt != 0, m_cnt, m_ovf, m_unf);
   endtask

   // Drive one cycle of inputs, clock it, and sample 1 time unit later.
   task automatic apply(input bit r, input bit pu, input bit po, input logic [AW-1:0] a,
                        input bit sv, input bit rs, input logic [1:0] id);
      rst = r; push = pu; pop = po; push_addr = a;
      ckpt_save = sv; ckpt_restore = rs; ckpt_id = id;
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic idle();
      apply(0, 0, 0, '0, 0, 0, 2'd0);
   endtask

   task automatic do_reset();
      apply(1, 0, 0, '0, 0, 0, 2'd0);
      rst = 0;
   endtask

   typedef struct {
      bit            pu, po;
      logic [AW-1:0] a;
      bit            sv, rs;
      logic [1:0]    id;
      logic [AW-1:0] e_ra;
      bit            e_v;
      int            e_cnt;
      bit            e_o, e_u;
   } vec_t;
   vec_t vecs[$];

   task automatic add(input bit pu, po, input logic [AW-1:0] a, input bit sv, rs,
                      input logic [1:0] id, input logic [AW-1:0] e_ra, input bit e_v,
                      input int e_cnt, input bit e_o, e_u);
      vecs.push_back('{pu, po, a, sv, rs, id, e_ra, e_v, e_cnt, e_o, e_u});
   endtask

   initial begin
      rst = 1; push = 0; pop = 0; push_addr = '0;
      ckpt_save = 0; ckpt_restore = 0; ckpt_id = '0;
      foreach (m_mem[i]) m_mem[i] = 0;

      // push pop addr save rest id | ra valid cnt ovf unf
      add(1, 0, 14'h010, 0, 0, 0, 14'h010, 1, 1, 0, 0);
      add(1, 0, 14'h020, 0, 0, 0, 14'h020, 1, 2, 0, 0);
      add(1, 0, 14'h030, 0, 0, 0, 14'h030, 1, 3, 0, 0);
      add(0, 1, 14'h000, 0, 0, 0, 14'h020, 1, 2, 0, 0);
      add(0, 1, 14'h000, 0, 0, 0, 14'h010, 1, 1, 0, 0);
      add(0, 1, 14'h000, 0, 0, 0, 14'h000, 0, 0, 0, 0);
      add(0, 1, 14'h000, 0, 0, 0, 14'h000, 0, 0, 0, 1);
      add(0, 0, 14'h000, 0, 0, 0, 14'h000, 0, 0, 0, 0);
      add(1, 0, 14'h001, 0, 0, 0, 14'h001, 1, 1, 0, 0);
      add(1, 0, 14'h002, 0, 0, 0, 14'h002, 1, 2, 0, 0);
      add(1, 0, 14'h003, 0, 0, 0, 14'h003, 1, 3, 0, 0);
      add(1, 0, 14'h004, 0, 0, 0, 14'h004, 1, 4, 0, 0);
      add(1, 0, 14'h005, 0, 0, 0, 14'h005, 1, 4, 1, 0);
      add(0, 1, 14'h000, 0, 0, 0, 14'h004, 1, 3, 0, 0);
      add(0, 1, 14'h000, 0, 0, 0, 14'h003, 1, 2, 0, 0);
      add(0, 1, 14'h000, 0, 0, 0, 14'h002, 1, 1, 0, 0);
      add(0, 1, 14'h000, 0, 0, 0, 14'h000, 0, 0, 0, 0);
      add(1, 0, 14'h100, 0, 0, 0, 14'h100, 1, 1, 0, 0);
      add(1, 1, 14'h200, 0, 0, 0, 14'h200, 1, 1, 0, 0);
      add(0, 1, 14'h000, 0, 0, 0, 14'h000, 0, 0, 0, 0);
      add(1, 1, 14'h200, 0, 0, 0, 14'h200, 1, 1, 0, 0);
      add(0, 1, 14'h000, 0, 0, 0, 14'h000, 0, 0, 0, 0);
      add(1, 0, 14'h0A0, 0, 0, 0, 14'h0A0, 1, 1, 0, 0);
      add(0, 0, 14'h000, 1, 0, 2, 14'h0A0, 1, 1, 0, 0);
      add(0, 1, 14'h000, 0, 0, 0, 14'h000, 0, 0, 0, 0);
      add(1, 0, 14'h0B0, 0, 0, 0, 14'h0B0, 1, 1, 0, 0);
      add(1, 0, 14'h0C0, 0, 0, 0, 14'h0C0, 1, 2, 0, 0);
      add(1, 0, 14'h0DD, 0, 1, 2, 14'h0A0, 1, 1, 0, 0);
      add(1, 0, 14'h0E0, 0, 0, 0, 14'h0E0, 1, 2, 0, 0);
      add(0, 0, 14'h000, 1, 1, 2, 14'h0A0, 1, 1, 0, 0);
      add(0, 1, 14'h000, 0, 1, 2, 14'h0A0, 1, 1, 0, 0);
      add(0, 1, 14'h000, 0, 0, 0, 14'h000, 0, 0, 0, 0);

      do_reset();
      chk_outs("reset", '0, 0, 0, 0, 0);

      for (int i = 0; i < vecs.size(); i++) begin
         apply(0, vecs[i].pu, vecs[i].po, vecs[i].a, vecs[i].sv, vecs[i].rs, vecs[i].id);
         chk_outs($sformatf("vec%0d", i), vecs[i].e_ra, vecs[i].e_v, vecs[i].e_cnt,
                  vecs[i].e_o, vecs[i].e_u);
      end

      // Restore from a never-saved slot after reset empties the stack.
      do_reset();
      apply(0, 1, 0, 14'h111, 0, 0, 2'd0);
      apply(0, 0, 0, '0, 0, 1, 2'd1);
      chk_outs("invalid_slot", '0, 0, 0, 0, 0);

      // Reset mid-operation drops entries and checkpoints.
      apply(0, 1, 0, 14'h0A1, 0, 0, 2'd0);
      apply(0, 1, 0, 14'h0A2, 1, 0, 2'd3);
      apply(0, 1, 0, 14'h0A3, 0, 0, 2'd0);
      chk_outs("pre_rst", 14'h0A3, 1, 3, 0, 0);
      do_reset();
      chk_outs("mid_rst", '0, 0, 0, 0, 0);
      apply(0, 0, 0, '0, 0, 1, 2'd3);
      chk_outs("rst_clears_ckpt", '0, 0, 0, 0, 0);

      // Random traffic against the model, with rare resets.
      for (int n = 0; n < 600; n++) begin
         automatic int  op = $urandom_range(0, 99);
         automatic bit  r  = ($urandom_range(0, 79) == 0);
         automatic bit  pu = (op < 45);
         automatic bit  po = (op >= 30 && op < 75);
         automatic bit  sv = ($urandom_range(0, 7) == 0);
         automatic bit  rs = ($urandom_range(0, 11) == 0);
         apply(r, pu, po, AW'($urandom), sv, rs, 2'($urandom_range(0, 3)));
         chk_model($sformatf("rand%0d", n));
      end
      idle();
      chk_model("final");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/ret_addr_stack.md
# ret_addr_stack

Parametrised return-address stack for the VLIW front end. It predicts return targets by pushing the link address on calls and popping on returns. The stack is circular and overwrites the oldest entry on overflow. It adds a small checkpoint file so the fetch unit can roll the stack back after a branch mispredict. It sits beside the fetch PC logic and feeds `ra` to next-PC selection.

## Interface
- `AW`, 14: address width in bits.
- `DEPTH_LOG2`, 4: log2 of entry count; `DEPTH` = 2**`DEPTH_LOG2`.
- `NCKPT`, 4: number of checkpoint slots; power of two, at least 2.
- `clk`  in  1  clock.
- `rst`  in  1  reset; synchronous, active-high; clock `clk`.
- `push`  in  1  call seen; push `push_addr`.
- `push_addr`  in  `AW`  return address to store (call PC + 1, computed by the caller).
- `pop`  in  1  return seen; pop top.
- `ra`  out  `AW`  predicted return address (top of stack); 0 when empty.
- `ra_valid`  out  1  stack non-empty.
- `count`  out  `DEPTH_LOG2`+1  valid entries, range 0..`DEPTH`.
- `overflow`  out  1  one-cycle pulse: a push overwrote the oldest entry.
- `underflow`  out  1  one-cycle pulse: a pop arrived while empty.
- `ckpt_save`  in  1  snapshot current state into slot `ckpt_id`.
- `ckpt_restore`  in  1  restore state from slot `ckpt_id`.
- `ckpt_id`  in  $clog2(`NCKPT`)  slot select.

## Operation
- **State**
  - `sp` (`DEPTH_LOG2` bits) points at the top entry.
  - `count` holds the number of valid entries.
  - The entry memory has `DEPTH` x `AW` bits and is not reset.
- **Outputs**
  - `ra` = `stack[sp]` when `count` != 0, else 0. Combinational from registered state.
  - `ra_valid` = (`count` != 0).
- **Push only**
  - `sp` <= `sp`+1, wrapping mod `DEPTH`.
  - `stack[sp+1]` <= `push_addr`.
  - `count` <= min(`count`+1, `DEPTH`).
  - If `count` == `DEPTH`, assert `overflow` for one cycle.
- **Pop only**
  - If `count` != 0: `sp` <= `sp`-1 (wrapping) and `count` <= `count`-1.
  - If `count` == 0: no state change; assert `underflow` for one cycle.
- **Push and pop together** (return immediately followed by call)
  - `stack[sp]` <= `push_addr`; `sp` unchanged.
  - `count` <= max(`count`, 1).
  - No `overflow` or `underflow` pulse.
- **Checkpoint save**
  - Slot `ckpt_id` <= {`sp`, `count`, `stack[sp]`}, using pre-update values.
  - A push or pop in the same cycle still executes normally.
- **Checkpoint restore**
  - `sp` and `count` <= saved values.
  - `stack[saved sp]` <= saved top value, which repairs a top clobbered by later pushes.
  - Restore has priority: `push` and `pop` are ignored that cycle.
  - `overflow` and `underflow` stay 0.
- **Save and restore together**: restore wins; the save is dropped.
- **Checkpoint slot validity**
  - Each slot has a valid bit; reset clears all of them.
  - Restore from an invalid slot resets `sp` and `count` to 0 and leaves memory untouched.

## Timing
- Reset values: `sp`=0, `count`=0, `ra`=0, `ra_valid`=0, `overflow`=0, `underflow`=0, all checkpoint valid bits 0.
- `rst` mid-operation discards all entries and checkpoints in one cycle.
- All state updates on the `clk` rising edge.
- Latency: a push at edge N makes `ra` = `push_addr` after edge N; no same-cycle bypass.
- Restore at edge N makes `ra` = the saved top value after edge N.
- `overflow` and `underflow` are registered pulses, visible the cycle after the offending request.

## Structure
- Shared package `ras_pkg`:
  - default `AW`, `DEPTH_LOG2`, `NCKPT`;
  - `ras_ckpt_t` struct {sp, count, top, valid}.
- Sub-module `ras_ckpt_file`: `NCKPT` entries of `ras_ckpt_t` with save/restore ports and a synchronous clear.
- The top level holds `sp`, `count`, the entry memory and the priority logic.

## Test plan
1. Reset, then push 0x010, 0x020, 0x030 on consecutive cycles.
   - `ra` = 0x010, 0x020, 0x030 in turn; `count` = 3.
   - Pop three times: `ra` = 0x020, 0x010, then 0 with `ra_valid`=0.
2. Wrap, with `DEPTH_LOG2`=2: push 0x001..0x005.
   - `overflow` pulses on the 5th push; `count` = 4.
   - Four pops return 0x005, 0x004, 0x003, 0x002; `count` = 0.
3. Empty pop: pop after reset.
   - `underflow` = 1 for one cycle; `sp`, `count` and `ra` unchanged.
4. Push and pop together: push 0x100, then push=pop=1 with 0x200.
   - `ra` = 0x200, `count` = 1.
   - The same cycle on an empty stack gives `count` = 1, `ra` = 0x200.
5. Checkpoint recovery: push 0x0A0; save slot 2; pop; push 0x0B0; push 0x0C0; restore slot 2.
   - `ra` = 0x0A0, `count` = 1.
   - A simultaneous push on the restore cycle is ignored.
6. Invalid slot and reset:
   - Restore from slot 1 after reset gives `count` = 0.
   - Assert `rst` with `count` = 3 gives all outputs 0 the next cycle.
